// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its neighbours: hazard unit,
// instruction memory, redirect source and the Decode stage.
interface fetch_stage_if;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        PCSrc;
    logic [31:0] BranchTarget;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [3:0]  Rn;
    logic [3:0]  Rm;
    logic [3:0]  Rd;
    logic [31:0] PCPlus4;
    logic        ValidD;
    logic        Halted;

    // master: the fetch stage itself
    modport master (
        input  StallF, StallD, FlushD, PCSrc, BranchTarget, InstrF,
        output PCF, InstrD, Rn, Rm, Rd, PCPlus4, ValidD, Halted
    );

    // slave: the surrounding pipeline / environment
    modport slave (
        output StallF, StallD, FlushD, PCSrc, BranchTarget, InstrF,
        input  PCF, InstrD, Rn, Rm, Rd, PCPlus4, ValidD, Halted
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register of the ARM calculator core. Owns the PC,
// handles stall/flush/redirect and a RUN/HALT FSM driven by the halt word.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_stage_if.master bus
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pcf;
    logic [31:0] r_instr_d;
    logic [31:0] r_pcplus4_d;
    logic        r_valid_d;

    logic [31:0] w_pcf_nxt;
    logic [31:0] w_instr_d_nxt;
    logic [31:0] w_pcplus4_d_nxt;
    logic        w_valid_d_nxt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_pc;
    logic        w_halt_word;
    logic        w_unused_bt;

    assign w_pc_plus4    = r_pcf + 32'd4;
    assign w_redirect_pc = {bus.BranchTarget[31:2], 2'b00};
    assign w_halt_word   = (bus.InstrF == HALT_INSTR);
    // Low target bits are dropped so the PC is always word-aligned.
    assign w_unused_bt   = |bus.BranchTarget[1:0];

    // FSM and PC next-state, in priority order: redirect, halt, stall, halt word.
    always_comb begin
        w_state_nxt = r_state;
        w_pcf_nxt   = r_pcf;
        if (bus.PCSrc) begin
            w_state_nxt = S_RUN;
            w_pcf_nxt   = w_redirect_pc;
        end else if (r_state == S_HALT) begin
            w_state_nxt = S_HALT;
        end else if (bus.StallF) begin
            w_state_nxt = S_RUN;
        end else if (w_halt_word) begin
            w_state_nxt = S_HALT;
        end else begin
            w_pcf_nxt   = w_pc_plus4;
        end
    end

    // IF/ID next-state: flush beats stall; the halt word is turned into a bubble.
    always_comb begin
        w_instr_d_nxt   = r_instr_d;
        w_pcplus4_d_nxt = r_pcplus4_d;
        w_valid_d_nxt   = r_valid_d;
        if (bus.FlushD || bus.PCSrc) begin
            w_instr_d_nxt   = '0;
            w_pcplus4_d_nxt = '0;
            w_valid_d_nxt   = 1'b0;
        end else if (bus.StallD) begin
            w_instr_d_nxt   = r_instr_d;
        end else if ((r_state == S_HALT) || w_halt_word) begin
            w_instr_d_nxt   = '0;
            w_pcplus4_d_nxt = '0;
            w_valid_d_nxt   = 1'b0;
        end else begin
            w_instr_d_nxt   = bus.InstrF;
            w_pcplus4_d_nxt = w_pc_plus4;
            w_valid_d_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_RUN;
            r_pcf       <= RESET_PC;
            r_instr_d   <= '0;
            r_pcplus4_d <= '0;
            r_valid_d   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pcf       <= w_pcf_nxt;
            r_instr_d   <= w_instr_d_nxt;
            r_pcplus4_d <= w_pcplus4_d_nxt;
            r_valid_d   <= w_valid_d_nxt;
        end
    end

    assign bus.PCF     = r_pcf;
    assign bus.InstrD  = r_instr_d;
    assign bus.Rn      = r_instr_d[19:16];
    assign bus.Rm      = r_instr_d[3:0];
    assign bus.Rd      = r_instr_d[15:12];
    assign bus.PCPlus4 = r_pcplus4_d;
    assign bus.ValidD  = r_valid_d;
    assign bus.Halted  = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, free run, stall, redirect, halt,
// wrap-around, flush and asynchronous reset, against hand-computed values.
module tb_fetch_stage;

    logic        clk;
    logic        reset_n;
    logic [31:0] imem [64];
    int          n_chk;
    int          n_fail;

    fetch_stage_if fif ();

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .HALT_INSTR (32'hFFFF_FFFF)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (fif.master)
    );

    // combinational instruction memory, word indexed
    assign fif.InstrF = imem[fif.PCF[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // one rising edge, then settle at the falling edge for checks/drive
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic sf, input logic sd, input logic fd,
                         input logic ps, input logic [31:0] bt);
        fif.StallF       = sf;
        fif.StallD       = sd;
        fif.FlushD       = fd;
        fif.PCSrc        = ps;
        fif.BranchTarget = bt;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        for (int k = 0; k < 64; k++) imem[k] = 32'hE280_0000 | k;
        imem[0] = 32'hE081_2003;
        imem[1] = 32'hE043_4005;
        imem[4] = 32'hFFFF_FFFF;   // halt word at 0x10

        reset_n = 1'b0;
        drive(0, 0, 0, 0, 32'h0);
        #2;
        chk("rst_pcf",    fif.PCF,            32'h0);
        chk("rst_instrd", fif.InstrD,         32'h0);
        chk("rst_pcp4",   fif.PCPlus4,        32'h0);
        chk("rst_valid",  {31'b0, fif.ValidD}, 32'h0);
        chk("rst_halted", {31'b0, fif.Halted}, 32'h0);
        chk("rst_rn",     {28'b0, fif.Rn},     32'h0);
        chk("rst_rd",     {28'b0, fif.Rd},     32'h0);
        chk("rst_rm",     {28'b0, fif.Rm},     32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // free run
        step();
        chk("c1_pcf",    fif.PCF,            32'h4);
        chk("c1_instrd", fif.InstrD,         32'hE081_2003);
        chk("c1_rn",     {28'b0, fif.Rn},     32'h1);
        chk("c1_rd",     {28'b0, fif.Rd},     32'h2);
        chk("c1_rm",     {28'b0, fif.Rm},     32'h3);
        chk("c1_pcp4",   fif.PCPlus4,        32'h4);
        chk("c1_valid",  {31'b0, fif.ValidD}, 32'h1);
        step();
        chk("c2_pcf",    fif.PCF,            32'h8);
        chk("c2_pcp4",   fif.PCPlus4,        32'h8);
        chk("c2_rn",     {28'b0, fif.Rn},     32'h3);
        chk("c2_rd",     {28'b0, fif.Rd},     32'h4);
        chk("c2_rm",     {28'b0, fif.Rm},     32'h5);

        // stall two cycles at PCF=8
        drive(1, 1, 0, 0, 32'h0);
        for (int c = 0; c < 2; c++) begin
            step();
            chk("stl_pcf",    fif.PCF,            32'h8);
            chk("stl_instrd", fif.InstrD,         32'hE043_4005);
            chk("stl_pcp4",   fif.PCPlus4,        32'h8);
            chk("stl_valid",  {31'b0, fif.ValidD}, 32'h1);
        end
        drive(0, 0, 0, 0, 32'h0);
        step();
        chk("rel_pcf",    fif.PCF,    32'hC);
        chk("rel_instrd", fif.InstrD, 32'hE280_0002);
        chk("rel_pcp4",   fif.PCPlus4, 32'hC);

        // redirect overrides stall, low target bits dropped
        drive(1, 0, 0, 1, 32'h0000_0043);
        step();
        chk("br_pcf",    fif.PCF,            32'h40);
        chk("br_valid",  {31'b0, fif.ValidD}, 32'h0);
        chk("br_instrd", fif.InstrD,         32'h0);
        drive(0, 0, 0, 0, 32'h0);
        step();
        chk("br2_instrd", fif.InstrD,         32'hE280_0010);
        chk("br2_valid",  {31'b0, fif.ValidD}, 32'h1);
        chk("br2_pcp4",   fif.PCPlus4,        32'h44);

        // halt at 0x10
        drive(0, 0, 0, 1, 32'h10);
        step();
        chk("h0_pcf", fif.PCF, 32'h10);
        drive(0, 0, 0, 0, 32'h0);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("h_halted", {31'b0, fif.Halted}, 32'h1);
            chk("h_pcf",    fif.PCF,            32'h10);
            chk("h_valid",  {31'b0, fif.ValidD}, 32'h0);
        end
        drive(0, 0, 0, 1, 32'h20);
        step();
        chk("hr_halted", {31'b0, fif.Halted}, 32'h0);
        chk("hr_pcf",    fif.PCF,            32'h20);
        drive(0, 0, 0, 0, 32'h0);
        step();
        chk("hr2_instrd", fif.InstrD,         32'hE280_0008);
        chk("hr2_valid",  {31'b0, fif.ValidD}, 32'h1);
        chk("hr2_pcf",    fif.PCF,            32'h24);

        // PC wrap
        drive(0, 0, 0, 1, 32'hFFFF_FFFC);
        step();
        chk("w_pcf", fif.PCF, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 32'h0);
        step();
        chk("w2_pcf",    fif.PCF,            32'h0);
        chk("w2_pcp4",   fif.PCPlus4,        32'h0);
        chk("w2_valid",  {31'b0, fif.ValidD}, 32'h1);
        chk("w2_instrd", fif.InstrD,         32'hE280_003F);

        // flush beats stall on IF/ID; PC still advances
        drive(0, 1, 1, 0, 32'h0);
        step();
        chk("fl_pcf",    fif.PCF,            32'h4);
        chk("fl_instrd", fif.InstrD,         32'h0);
        chk("fl_valid",  {31'b0, fif.ValidD}, 32'h0);

        // async reset at PCF=0x24, between edges
        drive(0, 0, 0, 1, 32'h24);
        step();
        drive(0, 0, 0, 0, 32'h0);
        chk("ar_pre_pcf", fif.PCF, 32'h24);
        #1 reset_n = 1'b0;
        #1;
        chk("ar_pcf",    fif.PCF,            32'h0);
        chk("ar_valid",  {31'b0, fif.ValidD}, 32'h0);
        chk("ar_halted", {31'b0, fif.Halted}, 32'h0);
        chk("ar_instrd", fif.InstrD,         32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("ar2_pcf",    fif.PCF,    32'h4);
        chk("ar2_instrd", fif.InstrD, 32'hE081_2003);

        // redirect together with halt word: no halt
        drive(0, 0, 0, 1, 32'h10);
        step();
        drive(0, 0, 0, 1, 32'h30);
        step();
        chk("ph_halted", {31'b0, fif.Halted}, 32'h0);
        chk("ph_pcf",    fif.PCF,            32'h30);

        // halt word under StallF: detected when stall releases
        drive(0, 0, 0, 1, 32'h10);
        step();
        drive(1, 0, 0, 0, 32'h0);
        step();
        chk("sh_halted", {31'b0, fif.Halted}, 32'h0);
        chk("sh_pcf",    fif.PCF,            32'h10);
        chk("sh_valid",  {31'b0, fif.ValidD}, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        step();
        chk("sh2_halted", {31'b0, fif.Halted}, 32'h1);
        chk("sh2_pcf",    fif.PCF,            32'h10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
